regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

- Shares the register file's single write port between two writeback requesters: requester 0 is the ALU result path, requester 1 is the load-return path.
- Each requester has a one-entry holding buffer behind a valid/ready handshake.
- An arbiter grants one buffered write per cycle and drives the register file write port from registered outputs.
- A pending-write mask lets the issue stage stall reads of registers with writes still in flight.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 4, register address width; the register file has 2**ADDR_W entries

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 offers a write
- req0_ready  out  1  requester 0 buffer can accept
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req1_valid, req1_ready, req1_addr, req1_data  same as requester 0, for requester 1
- rf_write_enable  out  1  register file write strobe, registered
- rf_address  out  ADDR_W  register file write address, registered
- rf_write_data  out  DATA_W  register file write data, registered
- pending_mask  out  2**ADDR_W  bit a = a write to register a is buffered or on the output stage

## Operation
**Buffers**
- Per requester: full flag, addr, data, and an age bit.
- A transfer occurs when valid && ready at a rising edge; the buffer captures addr and data and sets full.
- readyN = !fullN || grantN. A buffer draining this cycle can refill on the same edge.

**Grant**
- Computed combinationally from the full flags, age bits and the priority pointer only. Never from valid, so there is no loop.
- Only one buffer full: that buffer is granted.
- Both full, same address, different capture edges: the older entry is granted, so writes land in arrival order.
- Both full otherwise: the priority policy decides (see Configuration).

**Output stage**
- On a grant, at the next edge: rf_write_enable <= 1, rf_address/rf_write_data <= granted entry, granted buffer clears unless refilled.
- With no grant: rf_write_enable <= 0. rf_address and rf_write_data hold their previous values.

**Age bit**
- Set on a buffer when it captures while the other buffer is already full and not being granted.
- Cleared when that buffer is granted.

**Priority pointer**
- One bit; reset value 0, meaning requester 0 is preferred.
- After any cycle in which both buffers were full, the pointer points at the requester not granted.

**pending_mask**
- Combinational OR of three one-hot terms:
  - buffer0 address, when full0
  - buffer1 address, when full1
  - rf_address, when rf_write_enable

**Reset**
- On rst_n low, asynchronously:
  - both buffers empty, age bits 0, pointer 0
  - rf_write_enable 0, rf_address 0, rf_write_data 0
- Resulting outputs: req0_ready = req1_ready = 1, pending_mask = 0.
- Writes in flight when reset asserts are discarded.

## Timing
- Capture at edge k → rf_* valid during cycle k+1 → register file samples at edge k+2.
  - Minimum latency: 2 edges from handshake to architectural update.
- Aggregate throughput: one write per cycle.
  - A single requester streaming alone sustains one write per cycle.
- With both requesters streaming, each sustains one write per two cycles, alternating.
- pending_mask bit a goes high the cycle after the capture edge.
  - It clears in the cycle after the edge at which the register file sampled the write, unless another write to a is still queued.
- Simultaneous events on the same edge are legal:
  - capture into both buffers, and
  - drain of one buffer plus refill of the same buffer.
- Deassertion of rst_n is sampled synchronously by downstream logic. The block needs no further synchronisation.

## Configuration
- Macro `REGFILE_WB_RR_EN`.
- Defined: round-robin pointer as described; the older-first rule still overrides.
- Undefined: fixed priority, requester 0 always wins ties. The pointer flop is not built; the older-first rule still overrides.

## Test plan
- Reset: assert rst_n=0 mid-stream with both buffers full → rf_write_enable=0, pending_mask=0, both ready=1 immediately, with no clock edge required.
- Single stream: req0 writes r1=0x11, r2=0x22, r3=0x33 on consecutive cycles → rf_write_enable high for 3 consecutive cycles with addresses 1,2,3; req0_ready stays 1.
- Contention: both valid every cycle, req0 to r4 and req1 to r5, starting from reset → with RR, grants alternate 0,1,0,1; without RR, req0 is always granted and req1_ready stays 0 while req0 streams.
- Same-address ordering: req1 writes r7=0xAAAA at edge k, req0 writes r7=0xBBBB at edge k+1 while req1 is still held → r7 written 0xAAAA, then 0xBBBB; the final value is 0xBBBB.
- Hazard mask: single write to r9 → pending_mask[9] high for exactly 2 cycles starting the cycle after capture; all other bits 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback arbiter for the register file write port
//
// Requester 0 is the ALU result path and requester 1 is the load-return path.
// Each requester feeds a one-entry holding buffer through a valid/ready
// handshake. The arbiter grants one buffered write per cycle and drives the
// register file write port from registered outputs. pending_mask flags every
// register that still has a write buffered or on the output stage.
//
// Ports:
//   clk, rst_n                         clock (rising edge), asynchronous active-low reset
//   req0_valid/ready/addr/data         requester 0 (ALU) write handshake
//   req1_valid/ready/addr/data         requester 1 (load return) write handshake
//   rf_write_enable/address/write_data registered register file write port
//   pending_mask                       one bit per register, high while a write to it is in flight
//
// Configuration macro: REGFILE_WB_RR_EN
//   defined   - round-robin tie break between two full buffers
//   undefined - fixed priority, requester 0 wins ties (no pointer flop)
//   In both builds an older entry to the same address is granted first.

module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [ADDR_W-1:0]      req0_addr,
    input  logic [DATA_W-1:0]      req0_data,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [ADDR_W-1:0]      req1_addr,
    input  logic [DATA_W-1:0]      req1_data,

    output logic                   rf_write_enable,
    output logic [ADDR_W-1:0]      rf_address,
    output logic [DATA_W-1:0]      rf_write_data,

    output logic [(1<<ADDR_W)-1:0] pending_mask
);

    localparam int NREG = 1 << ADDR_W;

    // Holding buffers
    logic              full0, full1;
    logic              age0, age1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;

    logic grant0, grant1;
    logic cap0, cap1;
    logic prefer1;

    // Tie-break selection between two full buffers with no ordering constraint.
`ifdef REGFILE_WB_RR_EN
    logic ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (full0 && full1) begin
            // Point at whichever requester lost this cycle.
            ptr <= grant0;
        end
    end

    assign prefer1 = ptr;
`else
    assign prefer1 = 1'b0;
`endif

    // Grant depends only on buffer state, never on the incoming valids, so
    // ready (which uses the grant) has no combinational path from valid.
    // An age bit marks the younger of two entries; with equal addresses the
    // entry whose age bit is clear arrived first and must land first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0 && full1) begin
            if ((addr0 == addr1) && (age0 != age1)) begin
                grant0 = age1;
                grant1 = age0;
            end else begin
                grant0 = !prefer1;
                grant1 = prefer1;
            end
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    // A buffer being drained this cycle can accept a new entry on the same edge.
    assign req0_ready = !full0 || grant0;
    assign req1_ready = !full1 || grant1;

    assign cap0 = req0_valid && req0_ready;
    assign cap1 = req1_valid && req1_ready;

    // Buffer 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0 <= 1'b0;
            addr0 <= '0;
            data0 <= '0;
        end else if (cap0) begin
            full0 <= 1'b1;
            addr0 <= req0_addr;
            data0 <= req0_data;
        end else if (grant0) begin
            full0 <= 1'b0;
        end
    end

    // Buffer 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full1 <= 1'b0;
            addr1 <= '0;
            data1 <= '0;
        end else if (cap1) begin
            full1 <= 1'b1;
            addr1 <= req1_addr;
            data1 <= req1_data;
        end else if (grant1) begin
            full1 <= 1'b0;
        end
    end

    // Age bits. Capturing behind a held entry makes this entry the younger
    // one; the held entry then becomes the older and has its own age cleared
    // so that at most one age bit is ever set. Two captures on the same edge
    // cannot set both bits: a held (not granted) buffer is not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age0 <= 1'b0;
            age1 <= 1'b0;
        end else begin
            if (cap0 && full1 && !grant1) begin
                age0 <= 1'b1;
            end else if (grant0 || (cap1 && full0 && !grant0)) begin
                age0 <= 1'b0;
            end

            if (cap1 && full0 && !grant0) begin
                age1 <= 1'b1;
            end else if (grant1 || (cap0 && full1 && !grant1)) begin
                age1 <= 1'b0;
            end
        end
    end

    // Registered write port. Address and data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_enable <= 1'b0;
            rf_address      <= '0;
            rf_write_data   <= '0;
        end else if (grant0) begin
            rf_write_enable <= 1'b1;
            rf_address      <= addr0;
            rf_write_data   <= data0;
        end else if (grant1) begin
            rf_write_enable <= 1'b1;
            rf_address      <= addr1;
            rf_write_data   <= data1;
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

    // Hazard mask: every register with a write buffered or on the output stage.
    logic [NREG-1:0] hot0, hot1, hot_rf;

    always_comb begin
        hot0   = '0;
        hot1   = '0;
        hot_rf = '0;
        if (full0) begin
            hot0[addr0] = 1'b1;
        end
        if (full1) begin
            hot1[addr1] = 1'b1;
        end
        if (rf_write_enable) begin
            hot_rf[rf_address] = 1'b1;
        end
    end

    assign pending_mask = hot0 | hot1 | hot_rf;

endmodule
